// File: rtl/csr_access_unit_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | csr_access_unit_pkg                                                   |
// | Shared Zicsr opcode and sequencer state types for csr_access_unit.   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package csr_access_unit_pkg;

    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } csr_fsm_t;

    // Top two address bits equal to this mark the read-only CSR space.
    localparam logic [1:0] CSR_RO_MASK = 2'b11;

    function automatic logic csr_funct3_legal(input logic [2:0] funct3);
        return funct3[1:0] != 2'b00;
    endfunction

    function automatic logic csr_funct3_is_imm(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    function automatic logic csr_funct3_is_rw(input logic [2:0] funct3);
        return funct3[1:0] == 2'b01;
    endfunction

endpackage : csr_access_unit_pkg
`default_nettype wire

// File: rtl/csr_access_unit_rmw_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | csr_rmw_alu                                                           |
// | Combinational new-value computation for CSR read-modify-write.       |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module csr_rmw_alu
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  csr_op_t         op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] new_val
);

    always_comb begin
        new_val = operand;
        case (op)
            CSRRW, CSRRWI: new_val = operand;
            CSRRS, CSRRSI: new_val = old_val | operand;
            CSRRC, CSRRCI: new_val = old_val & ~operand;
            default:       new_val = operand;
        endcase
    end

endmodule : csr_rmw_alu
`default_nettype wire

// File: rtl/csr_access_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | csr_access_unit                                                       |
// | Sequenced read-modify-write initiator for one Zicsr instruction.     |
// | Optional: CSR_ACCESS_RO_TRAP_EN traps writes to read-only CSR space. |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_rs1_val,
    input  logic [4:0]        req_uimm,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_illegal,
    output logic [ADDR_W-1:0] csr_addr,
    output logic              csr_wr,
    output logic [XLEN-1:0]   csr_wrdata,
    input  logic [XLEN-1:0]   csr_rdata
);

    csr_fsm_t        state;
    csr_fsm_t        state_next;
    csr_op_t         r_op;
    logic [XLEN-1:0] r_operand;
    logic            r_we;

    logic            w_accept;
    logic            w_legal;
    logic            w_we;
    logic [XLEN-1:0] w_operand;
    logic [XLEN-1:0] w_new;
    logic            w_ro_trap;

    assign w_accept  = req_valid && (state == IDLE);
    assign w_legal   = csr_funct3_legal(req_funct3);
    // A zero rs1 field (x0 or uimm 0) suppresses the write for set/clear forms.
    assign w_we      = csr_funct3_is_rw(req_funct3) || (req_uimm != 5'd0);
    assign w_operand = csr_funct3_is_imm(req_funct3) ? {{(XLEN-5){1'b0}}, req_uimm}
                                                     : req_rs1_val;

`ifdef CSR_ACCESS_RO_TRAP_EN
    assign w_ro_trap = r_we && (csr_addr[ADDR_W-1 -: 2] == CSR_RO_MASK);
`else
    assign w_ro_trap = 1'b0;
`endif

    csr_rmw_alu #(
        .XLEN (XLEN)
    ) u_rmw_alu (
        .op      (r_op),
        .old_val (csr_rdata),
        .operand (r_operand),
        .new_val (w_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        csr_wr     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    state_next = w_legal ? READ : RESP;
                end
            end
            READ: begin
                state_next = (r_we && !w_ro_trap) ? WRITE : RESP;
            end
            WRITE: begin
                csr_wr     = !rst;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= CSRRW;
            r_operand    <= '0;
            r_we         <= 1'b0;
            csr_addr     <= '0;
            csr_wrdata   <= '0;
            resp_rdata   <= '0;
            resp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_op         <= csr_op_t'(req_funct3);
                            r_operand    <= w_operand;
                            r_we         <= w_we;
                            csr_addr     <= req_addr;
                            resp_illegal <= 1'b0;
                        end else begin
                            r_we         <= 1'b0;
                            resp_rdata   <= '0;
                            resp_illegal <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (w_ro_trap) begin
                        resp_rdata   <= '0;
                        resp_illegal <= 1'b1;
                    end else begin
                        resp_rdata <= csr_rdata;
                        if (r_we) begin
                            csr_wrdata <= w_new;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : csr_access_unit
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// Directed self-checking bench for csr_access_unit.
module tb_csr_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_val;
    logic [4:0]  req_uimm;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic [11:0] csr_addr;
    logic        csr_wr;
    logic [31:0] csr_wrdata;
    logic [31:0] csr_rdata;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    int wc;

    csr_access_unit #(
        .XLEN   (32),
        .ADDR_W (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_rs1_val  (req_rs1_val),
        .req_uimm     (req_uimm),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_illegal (resp_illegal),
        .csr_addr     (csr_addr),
        .csr_wr       (csr_wr),
        .csr_wrdata   (csr_wrdata),
        .csr_rdata    (csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (csr_wr === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] rs1, input logic [4:0] uimm,
                         input logic [31:0] rdata);
        req_valid   = 1'b1;
        req_funct3  = f3;
        req_addr    = addr;
        req_rs1_val = rs1;
        req_uimm    = uimm;
        csr_rdata   = rdata;
        tick;
        req_valid   = 1'b0;
    endtask

    task automatic handshake;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        check("hs_rvalid_drop", {31'b0, resp_valid}, 32'd0);
        check("hs_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'b000; req_addr = 12'h0;
        req_rs1_val = 32'h0; req_uimm = 5'd0; resp_ready = 1'b0; csr_rdata = 32'h0;
        tick;
        check("rst_wr", {31'b0, csr_wr}, 32'd0);
        tick;
        rst = 1'b0;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_illegal", {31'b0, resp_illegal}, 32'd0);
        check("rst_csr_addr", {20'b0, csr_addr}, 32'd0);
        check("rst_csr_wrdata", csr_wrdata, 32'd0);

        // CSRRW 0x305
        issue(3'b001, 12'h305, 32'h8000_0100, 5'd1, 32'h0);
        check("rw_read_ready", {31'b0, req_ready}, 32'd0);
        check("rw_read_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rw_read_addr", {20'b0, csr_addr}, 32'h305);
        check("rw_read_wr", {31'b0, csr_wr}, 32'd0);
        tick;
        check("rw_write_wr", {31'b0, csr_wr}, 32'd1);
        check("rw_write_data", csr_wrdata, 32'h8000_0100);
        check("rw_write_addr", {20'b0, csr_addr}, 32'h305);
        tick;
        check("rw_resp_wr", {31'b0, csr_wr}, 32'd0);
        check("rw_resp_rvalid", {31'b0, resp_valid}, 32'd1);
        check("rw_resp_rdata", resp_rdata, 32'h0);
        check("rw_resp_illegal", {31'b0, resp_illegal}, 32'd0);
        check("rw_wr_count", wr_count, 32'd1);
        handshake;

        // CSRRS with zero rs1 field: read only, then backpressure
        wc = wr_count;
        issue(3'b010, 12'h300, 32'hFFFF_FFFF, 5'd0, 32'h0000_1888);
        check("rs0_read_wr", {31'b0, csr_wr}, 32'd0);
        tick;
        check("rs0_resp_rvalid", {31'b0, resp_valid}, 32'd1);
        check("rs0_resp_rdata", resp_rdata, 32'h0000_1888);
        csr_rdata   = 32'hDEAD_BEEF;
        req_valid   = 1'b1;
        req_funct3  = 3'b001;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("hold_rvalid", {31'b0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, 32'h0000_1888);
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        handshake;
        check("rs0_no_write", wr_count, wc);

        // CSRRCI uimm=8
        issue(3'b111, 12'h300, 32'h0, 5'h08, 32'h0000_0088);
        tick;
        check("rci_wr", {31'b0, csr_wr}, 32'd1);
        check("rci_wrdata", csr_wrdata, 32'h0000_0080);
        tick;
        check("rci_rvalid", {31'b0, resp_valid}, 32'd1);
        check("rci_rdata", resp_rdata, 32'h0000_0088);
        handshake;

        // CSRRS with nonzero rs1 field
        issue(3'b010, 12'h340, 32'h0000_0F00, 5'd1, 32'h0000_00F0);
        tick;
        check("rs_wr", {31'b0, csr_wr}, 32'd1);
        check("rs_wrdata", csr_wrdata, 32'h0000_0FF0);
        tick;
        check("rs_rdata", resp_rdata, 32'h0000_00F0);
        handshake;

        // Illegal funct3 100
        wc = wr_count;
        issue(3'b100, 12'h123, 32'h1, 5'd3, 32'h5555_5555);
        check("ill_rvalid", {31'b0, resp_valid}, 32'd1);
        check("ill_flag", {31'b0, resp_illegal}, 32'd1);
        check("ill_rdata", resp_rdata, 32'h0);
        check("ill_wr", {31'b0, csr_wr}, 32'd0);
        tick;
        check("ill_hold", {31'b0, resp_valid}, 32'd1);
        handshake;
        check("ill_no_write", wr_count, wc);

        // CSRRW to read-only space 0xF11
        wc = wr_count;
        issue(3'b001, 12'hF11, 32'h0000_0055, 5'd2, 32'h0000_0077);
        tick;
`ifdef CSR_ACCESS_RO_TRAP_EN
        check("ro_rvalid", {31'b0, resp_valid}, 32'd1);
        check("ro_illegal", {31'b0, resp_illegal}, 32'd1);
        check("ro_rdata", resp_rdata, 32'h0);
        check("ro_wr", {31'b0, csr_wr}, 32'd0);
        handshake;
        check("ro_no_write", wr_count, wc);
`else
        check("ro_wr", {31'b0, csr_wr}, 32'd1);
        check("ro_wrdata", csr_wrdata, 32'h0000_0055);
        tick;
        check("ro_rvalid", {31'b0, resp_valid}, 32'd1);
        check("ro_illegal", {31'b0, resp_illegal}, 32'd0);
        check("ro_rdata", resp_rdata, 32'h0000_0077);
        handshake;
        check("ro_one_write", wr_count, wc + 1);
`endif

        // CSRRS x0 to 0xF11 is always a legal read
        issue(3'b010, 12'hF11, 32'hFFFF_FFFF, 5'd0, 32'h0000_0012);
        tick;
        check("rox0_rvalid", {31'b0, resp_valid}, 32'd1);
        check("rox0_illegal", {31'b0, resp_illegal}, 32'd0);
        check("rox0_rdata", resp_rdata, 32'h0000_0012);
        handshake;

        // Reset while in WRITE
        issue(3'b001, 12'h305, 32'h0000_1234, 5'd1, 32'h0);
        tick;
        check("rstw_wr_pre", {31'b0, csr_wr}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstw_wr_gated", {31'b0, csr_wr}, 32'd0);
        wc = wr_count;
        tick;
        check("rstw_ready", {31'b0, req_ready}, 32'd1);
        check("rstw_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rstw_wr", {31'b0, csr_wr}, 32'd0);
        rst = 1'b0;
        tick;
        check("rstw_rvalid_after", {31'b0, resp_valid}, 32'd0);
        check("rstw_ready_after", {31'b0, req_ready}, 32'd1);
        check("rstw_no_write", wr_count, wc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_csr_access_unit
`default_nettype wire

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR read/write port: executes one Zicsr instruction (CSRRW/RS/RC and immediate forms) as a sequenced read-modify-write against the CSR register file.
- Sits between decode/execute and the CSR file.
- Accepts requests over a valid/ready handshake and returns the old CSR value for rd over a second valid/ready handshake.

Parameters:
- XLEN, 32, data width of CSR values and rs1 operand.
- ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_funct3  in  3  Zicsr funct3
- req_addr  in  ADDR_W  target CSR address
- req_rs1_val  in  XLEN  rs1 register value
- req_uimm  in  5  rs1 field, used as zero-extended immediate
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  XLEN  old CSR value for rd
- resp_illegal  out  1  illegal-instruction indication
- csr_addr  out  ADDR_W  address to CSR file
- csr_wr  out  1  one-cycle write strobe to CSR file
- csr_wrdata  out  XLEN  write data to CSR file
- csr_rdata  in  XLEN  combinational read data from CSR file for csr_addr

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. After reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_illegal=0, csr_addr=0, csr_wr=0, csr_wrdata=0.
- csr_wr is gated with !rst, so no write is ever presented in a cycle where rst=1.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, capture funct3, addr, operand and write-enable. Go to READ, or to RESP with resp_illegal=1 for funct3 000/100.
- Operand: req_rs1_val for funct3 001/010/011; {27'b0, req_uimm} for 101/110/111.
- Write-enable: always for RW/RWI. For RS/RC/RSI/RCI only when req_uimm != 0 (rs1 field nonzero; x0 suppresses the write).
- READ: csr_addr=captured addr; latch csr_rdata into old. Compute new value:
  - RW: new = op
  - RS: new = old | op
  - RC: new = old & ~op
- READ exit: go to WRITE if write-enabled and legal, else RESP.
- WRITE: csr_wr=1 for exactly one cycle, csr_wrdata=new, csr_addr unchanged. Then go to RESP.
- RESP: resp_valid=1, resp_rdata=old (0 if illegal). All outputs held stable until resp_ready. On resp_valid&resp_ready go to IDLE, and resp_valid drops the next cycle.
- No new request is accepted during RESP (no bypass). req_ready=0 outside IDLE.
- Latency, accept edge to resp_valid: 3 cycles with a write, 2 without, 1 for illegal funct3.
- csr_addr holds its last value in IDLE/RESP. csr_wrdata holds its last value; only csr_wr qualifies it.
- Reset mid-operation: any state returns to IDLE. A pending write is dropped and a pending response is discarded.

Optional Feature:
- Macro CSR_ACCESS_RO_TRAP_EN.
- Defined: a write-enabled access to an address with addr[11:10]==2'b11 (read-only space) skips WRITE and responds resp_illegal=1, resp_rdata=0. A read-only access, such as CSRRS x0 to 0xF11, is legal.
- Undefined: no address check. The write is issued and ignored by the CSR file. resp_illegal is set only for illegal funct3.

Decomposition:
- Shared instructions package:
  - csr_op_t enum for funct3 encodings (CSRRW=3'b001 … CSRRCI=3'b111)
  - csr_fsm_t state enum
  - CSR_RO_MASK constant 2'b11
- One natural sub-module: csr_rmw_alu, combinational (op, old, operand → new).

Test Plan:
- CSRRW 0x305, rs1=0x8000_0100, csr_rdata=0 → csr_wr pulse at cycle 2 with wrdata 0x8000_0100; resp_rdata=0 at cycle 3.
- CSRRS 0x300, uimm field=0, csr_rdata=0x0000_1888 → no csr_wr; resp_valid at cycle 2 with rdata 0x0000_1888.
- CSRRCI 0x300, uimm=0x08, csr_rdata=0x88 → csr_wrdata 0x80; resp_rdata 0x88.
- Hold resp_ready=0 for 5 cycles → resp_valid/rdata stable, req_ready=0, no second csr_wr; IDLE one cycle after resp_ready=1.
- funct3=3'b100 → resp_illegal=1 after 1 cycle; csr_wr never asserted.
- With CSR_ACCESS_RO_TRAP_EN, CSRRW 0xF11 → resp_illegal=1, no csr_wr. Separately, assert rst in WRITE state → csr_wr=0 that cycle, IDLE next, resp_valid stays 0.
